// File: rtl/sram_sync_ctrl_if.sv
// -----------------------------------------------------------------------------
// sram_sync_ctrl_if
// Request/response bundle between a requester and the SRAM controller.
//
//   req_valid   requester -> ctrl  request present
//   req_ready   ctrl -> requester  controller idle, request will be accepted
//   req_we      requester -> ctrl  1 = write, 0 = read
//   req_addr    requester -> ctrl  word address
//   req_wdata   requester -> ctrl  write data
//   req_be      requester -> ctrl  byte enables, [1] upper, [0] lower
//   resp_valid  ctrl -> requester  one-cycle completion pulse
//   resp_rdata  ctrl -> requester  read data, held until the next read
//
// Modports: master = requester side, slave = controller side.
// -----------------------------------------------------------------------------
interface sram_sync_ctrl_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 16
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [1:0]        req_be;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;

    modport master (
        output req_valid,
        output req_we,
        output req_addr,
        output req_wdata,
        output req_be,
        input  req_ready,
        input  resp_valid,
        input  resp_rdata
    );

    modport slave (
        input  req_valid,
        input  req_we,
        input  req_addr,
        input  req_wdata,
        input  req_be,
        output req_ready,
        output resp_valid,
        output resp_rdata
    );
endinterface

// File: rtl/sram_sync_ctrl.sv
// -----------------------------------------------------------------------------
// sram_sync_ctrl
// Synchronous front-end for a 512x16 asynchronous SRAM (active-low CE/OE/WE/
// UB/LB). Takes single-word read/write requests over a valid/ready handshake,
// sequences the SRAM strobes and the shared data bus with cycle-counted
// setup / pulse / turnaround phases, and answers with a one-cycle resp_valid.
//
// Ports
//   clk        single clock, rising edge
//   rst_n      asynchronous active-low reset
//   req        request/response bundle (slave side of sram_sync_ctrl_if)
//   sram_addr  SRAM word address (registered)
//   sram_data  SRAM bidirectional data bus, driven only in the write states
//   sram_ce_n  chip enable      (registered, active low)
//   sram_oe_n  output enable    (registered, active low)
//   sram_we_n  write enable     (registered, active low)
//   sram_ub_n  upper byte lane  (registered, active low)
//   sram_lb_n  lower byte lane  (registered, active low)
//
// Every SRAM-facing output is computed from the *next* state and registered,
// so in any cycle the pins show exactly the pattern of the current state.
// -----------------------------------------------------------------------------
module sram_sync_ctrl #(
    parameter int ADDR_W     = 9,
    parameter int DATA_W     = 16,
    parameter int READ_WAIT  = 2,
    parameter int WRITE_WAIT = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    sram_sync_ctrl_if.slave       req,
    output logic [ADDR_W-1:0]     sram_addr,
    inout  wire  [DATA_W-1:0]     sram_data,
    output logic                  sram_ce_n,
    output logic                  sram_oe_n,
    output logic                  sram_we_n,
    output logic                  sram_ub_n,
    output logic                  sram_lb_n
);

    // A wait of zero would never assert the strobe; clamp to one cycle.
    localparam int RD_CYC  = (READ_WAIT  < 1) ? 1 : READ_WAIT;
    localparam int WR_CYC  = (WRITE_WAIT < 1) ? 1 : WRITE_WAIT;
    localparam int MAX_CYC = (RD_CYC > WR_CYC) ? RD_CYC : WR_CYC;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam int LANE_W  = DATA_W / 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_TURN,
        S_WR_SETUP,
        S_WR_PULSE,
        S_WR_HOLD
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    // Request fields captured at accept and held for the whole operation.
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [1:0]          be_q;

    // Registered SRAM strobes and bus drive enable.
    logic                ce_n_q, ce_n_d;
    logic                oe_n_q, oe_n_d;
    logic                we_n_q, we_n_d;
    logic                ub_n_q, ub_n_d;
    logic                lb_n_q, lb_n_d;
    logic                drive_q, drive_d;

    // Registered response.
    logic                resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    logic                accept;
    logic                rd_last;
    logic                wr_last;
    logic [1:0]          be_sel;
    logic [DATA_W-1:0]   rdata_masked;

    assign accept  = req.req_valid && (state_q == S_IDLE);
    assign rd_last = (cnt_q == CNT_W'(RD_CYC - 1));
    assign wr_last = (cnt_q == CNT_W'(WR_CYC - 1));

    // Lane enables for the next cycle: at accept the capture registers are
    // still loading, so take them straight from the request.
    assign be_sel = accept ? req.req_be : be_q;

    // Disabled byte lanes read back as zero regardless of what the bus holds
    // (an unselected SRAM lane floats).
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_lane
            assign rdata_masked[gi*LANE_W +: LANE_W] =
                be_q[gi] ? sram_data[gi*LANE_W +: LANE_W] : '0;
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Next-state, counter and response logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        resp_valid_d = 1'b0;
        rdata_d      = rdata_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    cnt_d   = '0;
                    state_d = req.req_we ? S_WR_SETUP : S_READ;
                end
            end

            S_READ: begin
                if (rd_last) begin
                    // Data has been valid for the whole access time by now.
                    rdata_d      = rdata_masked;
                    resp_valid_d = 1'b1;
                    state_d      = S_TURN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_TURN: begin
                state_d = S_IDLE;
            end

            S_WR_SETUP: begin
                cnt_d   = '0;
                state_d = S_WR_PULSE;
            end

            S_WR_PULSE: begin
                if (wr_last) begin
                    resp_valid_d = 1'b1;
                    state_d      = S_WR_HOLD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_WR_HOLD: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Strobe pattern of the next state
    // -------------------------------------------------------------------------
    always_comb begin
        ce_n_d  = 1'b1;
        oe_n_d  = 1'b1;
        we_n_d  = 1'b1;
        ub_n_d  = 1'b1;
        lb_n_d  = 1'b1;
        drive_d = 1'b0;

        case (state_d)
            S_READ: begin
                ce_n_d = 1'b0;
                oe_n_d = 1'b0;
                ub_n_d = ~be_sel[1];
                lb_n_d = ~be_sel[0];
            end

            // Setup and hold keep the bus driven with WE_n high so the data
            // is stable on both sides of the write pulse, and the address is
            // already settled when WE_n falls.
            S_WR_SETUP, S_WR_HOLD: begin
                ce_n_d  = 1'b0;
                ub_n_d  = ~be_sel[1];
                lb_n_d  = ~be_sel[0];
                drive_d = 1'b1;
            end

            S_WR_PULSE: begin
                ce_n_d  = 1'b0;
                we_n_d  = 1'b0;
                ub_n_d  = ~be_sel[1];
                lb_n_d  = ~be_sel[0];
                drive_d = 1'b1;
            end

            default: begin
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            ce_n_q       <= 1'b1;
            oe_n_q       <= 1'b1;
            we_n_q       <= 1'b1;
            ub_n_q       <= 1'b1;
            lb_n_q       <= 1'b1;
            drive_q      <= 1'b0;
            resp_valid_q <= 1'b0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ce_n_q       <= ce_n_d;
            oe_n_q       <= oe_n_d;
            we_n_q       <= we_n_d;
            ub_n_q       <= ub_n_d;
            lb_n_q       <= lb_n_d;
            drive_q      <= drive_d;
            resp_valid_q <= resp_valid_d;
            rdata_q      <= rdata_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
        end else if (accept) begin
            addr_q  <= req.req_addr;
            wdata_q <= req.req_wdata;
            be_q    <= req.req_be;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign req.req_ready  = (state_q == S_IDLE);
    assign req.resp_valid = resp_valid_q;
    assign req.resp_rdata = rdata_q;

    assign sram_addr = addr_q;
    assign sram_ce_n = ce_n_q;
    assign sram_oe_n = oe_n_q;
    assign sram_we_n = we_n_q;
    assign sram_ub_n = ub_n_q;
    assign sram_lb_n = lb_n_q;
    assign sram_data = drive_q ? wdata_q : {DATA_W{1'bz}};

endmodule
